ft_tx_arbiter: RTL and testbench



---
 rtl/ft_pkg.sv | 23 ++
 rtl/ft_tx_arbiter_if.sv | 31 +++
 rtl/rr_arbiter.sv | 28 ++
 rtl/ft_tx_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ft_tx_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ft_pkg.sv
// Shared types and header layout for the FT TX arbiter.
// FT_ARB_TIMEOUT_EN adds the PAD state used to pad out a stalled burst.
package ft_pkg;

  localparam int FT_HDR_CHAN_BITS = 4;
  localparam int FT_LEN_BITS      = 8;
  localparam int FT_HDR_LEN_LSB   = 0;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HEADER,
    ARB_DATA
`ifdef FT_ARB_TIMEOUT_EN
    , ARB_PAD
`endif
  } ft_arb_state_t;

  function automatic logic [FT_LEN_BITS-1:0] ft_clip_len(input logic [FT_LEN_BITS-1:0] len,
                                                         input logic [FT_LEN_BITS-1:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/ft_tx_arbiter_if.sv
// Source-side and bridge-side signals of the FT TX arbiter.
// master = arbiter view, slave = sources plus bridge view.
interface ft_tx_arbiter_if
  import ft_pkg::*;
#(
  parameter int BUS_WIDTH = 16,
  parameter int CHANNELS  = 4
);
  logic [CHANNELS-1:0]                 src_req;
  logic [CHANNELS*FT_LEN_BITS-1:0]     src_len;
  logic [CHANNELS-1:0]                 src_ack;
  logic [CHANNELS*BUS_WIDTH-1:0]       src_data;
  logic [CHANNELS*(BUS_WIDTH/8)-1:0]   src_be;
  logic [CHANNELS-1:0]                 src_valid;
  logic [CHANNELS-1:0]                 src_ready;
  logic [BUS_WIDTH-1:0]                ft_din;
  logic [BUS_WIDTH/8-1:0]              ft_din_be;
  logic                                ft_din_valid;
  logic                                ft_din_full;
  logic                                abort;

  modport master (
    input  src_req, src_len, src_data, src_be, src_valid, ft_din_full,
    output src_ack, src_ready, ft_din, ft_din_be, ft_din_valid, abort
  );

  modport slave (
    output src_req, src_len, src_data, src_be, src_valid, ft_din_full,
    input  src_ack, src_ready, ft_din, ft_din_be, ft_din_valid, abort
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_i, wrapping.
// No state; the caller owns last_i.
module rr_arbiter #(
  parameter  int CHANNELS = 4,
  localparam int CW       = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [CW-1:0]       last_i,
  output logic [CW-1:0]       gnt_o,
  output logic                any_o
);

  logic [CW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = CW'((int'(last_i) + i) % CHANNELS);
      if (!any_o && req_i[idx]) begin
        gnt_o = idx;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ft_tx_arbiter.sv
// Round-robin scheduler sharing the FT bridge write port: header word, then len data words.
// FT_ARB_TIMEOUT_EN: stalled bursts are aborted after TIMEOUT idle cycles and zero-padded.
module ft_tx_arbiter
  import ft_pkg::*;
#(
  parameter int BUS_WIDTH = 16,
  parameter int CHANNELS  = 4,
  parameter int MAX_BURST = 64,
  parameter int TIMEOUT   = 256
) (
  input  logic            clk,
  input  logic            rst,
  ft_tx_arbiter_if.master bus
);

  localparam int CW  = $clog2(CHANNELS);
  localparam int BEW = BUS_WIDTH / 8;
  localparam logic [FT_LEN_BITS-1:0] MAX_LEN = FT_LEN_BITS'(MAX_BURST);

  ft_arb_state_t          state_q, state_d;
  logic [CW-1:0]          grant_q, grant_d;
  logic [CW-1:0]          last_grant_q, last_grant_d;
  logic [FT_LEN_BITS-1:0] remaining_q, remaining_d;

  logic [CW-1:0]          rr_gnt;
  logic                   rr_any;
  logic [FT_LEN_BITS-1:0] req_len;
  logic [BUS_WIDTH-1:0]   sel_data;
  logic [BEW-1:0]         sel_be;
  logic                   sel_valid;
  logic                   xfer;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_rr (
    .req_i  (bus.src_req),
    .last_i (last_grant_q),
    .gnt_o  (rr_gnt),
    .any_o  (rr_any)
  );

  always_comb begin
    sel_data  = '0;
    sel_be    = '0;
    sel_valid = 1'b0;
    req_len   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_q == CW'(i)) begin
        sel_data  = bus.src_data[i*BUS_WIDTH +: BUS_WIDTH];
        sel_be    = bus.src_be[i*BEW +: BEW];
        sel_valid = bus.src_valid[i];
      end
      if (rr_gnt == CW'(i)) begin
        req_len = bus.src_len[i*FT_LEN_BITS +: FT_LEN_BITS];
      end
    end
  end

`ifdef FT_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          stall_cyc;
  logic          stall_hit;

  // A stall is a cycle where the bridge could take a word but the source has none.
  assign stall_cyc = (state_q == ARB_DATA) && !sel_valid && !bus.ft_din_full;
  assign stall_hit = stall_cyc && (stall_q == SW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= CW'(CHANNELS - 1);
      remaining_q  <= '0;
`ifdef FT_ARB_TIMEOUT_EN
      stall_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      remaining_q  <= remaining_d;
`ifdef FT_ARB_TIMEOUT_EN
      stall_q      <= stall_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    remaining_d  = remaining_q;
`ifdef FT_ARB_TIMEOUT_EN
    stall_d      = '0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (rr_any) begin
          grant_d     = rr_gnt;
          remaining_d = ft_clip_len(req_len, MAX_LEN);
          state_d     = ARB_HEADER;
        end
      end
      ARB_HEADER: begin
        if (xfer) begin
          last_grant_d = grant_q;
          state_d      = (remaining_q == '0) ? ARB_IDLE : ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (xfer) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == FT_LEN_BITS'(1)) state_d = ARB_IDLE;
        end
`ifdef FT_ARB_TIMEOUT_EN
        else begin
          stall_d = stall_cyc ? stall_q + SW'(1) : stall_q;
          if (stall_hit) begin
            stall_d = '0;
            state_d = ARB_PAD;
          end
        end
`endif
      end
`ifdef FT_ARB_TIMEOUT_EN
      ARB_PAD: begin
        if (xfer) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == FT_LEN_BITS'(1)) state_d = ARB_IDLE;
        end
      end
`endif
      default: state_d = ARB_IDLE;
    endcase
  end

  // Outputs are gated by rst so valid drops in the same cycle reset is raised.
  always_comb begin
    xfer              = 1'b0;
    bus.ft_din        = '0;
    bus.ft_din_be     = '0;
    bus.src_ack       = '0;
    bus.src_ready     = '0;
    bus.abort         = 1'b0;
    if (!rst) begin
      case (state_q)
        ARB_HEADER: begin
          bus.ft_din[BUS_WIDTH-1 -: FT_HDR_CHAN_BITS]        = FT_HDR_CHAN_BITS'(grant_q);
          bus.ft_din[FT_HDR_LEN_LSB +: FT_LEN_BITS]          = remaining_q;
          bus.ft_din_be = '1;
          xfer          = !bus.ft_din_full;
          for (int i = 0; i < CHANNELS; i++)
            bus.src_ack[i] = xfer && (grant_q == CW'(i));
        end
        ARB_DATA: begin
          bus.ft_din    = sel_data;
          bus.ft_din_be = sel_be;
          xfer          = sel_valid && !bus.ft_din_full;
          for (int i = 0; i < CHANNELS; i++)
            bus.src_ready[i] = !bus.ft_din_full && (grant_q == CW'(i));
`ifdef FT_ARB_TIMEOUT_EN
          bus.abort = stall_hit;
`endif
        end
`ifdef FT_ARB_TIMEOUT_EN
        ARB_PAD: xfer = !bus.ft_din_full;
`endif
        default: xfer = 1'b0;
      endcase
    end
    bus.ft_din_valid = xfer;
  end

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Directed bench for ft_tx_arbiter; the timeout scenario follows FT_ARB_TIMEOUT_EN.
module tb_ft_tx_arbiter;

  localparam int BW = 16;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  ft_tx_arbiter_if #(.BUS_WIDTH(BW), .CHANNELS(CH)) bus ();

  ft_tx_arbiter #(.BUS_WIDTH(BW), .CHANNELS(CH), .MAX_BURST(64), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int ch, input int len);
    bus.src_len[ch*8 +: 8] = 8'(len);
  endtask

  task automatic set_data(input int ch, input logic [BW-1:0] d);
    bus.src_data[ch*BW +: BW] = d;
    bus.src_be[ch*2 +: 2]     = 2'b11;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.src_req = '1;
    bus.src_valid = '1;
    step(); step(); #1;
    checks++; if (bus.ft_din_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.ft_din_valid); end
    checks++; if (bus.ft_din !== 16'h0000) begin errors++; $display("FAIL reset_din: got %h want 0000", bus.ft_din); end
    checks++; if (bus.ft_din_be !== 2'b00) begin errors++; $display("FAIL reset_be: got %b want 00", bus.ft_din_be); end
    checks++; if (bus.src_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", bus.src_ack); end
    checks++; if (bus.src_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", bus.src_ready); end
    checks++; if (bus.abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b want 0", bus.abort); end
    rst = 1'b0;
    bus.src_req = '0;
    bus.src_valid = '0;
  endtask

  task automatic test_single_packet();
    step();
    bus.src_req = 4'b0100; set_len(2, 3); bus.src_valid[2] = 1'b1; set_data(2, 16'hA0A0); #1;
    checks++; if (bus.ft_din_valid !== 1'b0) begin errors++; $display("FAIL single_idle: valid=%b want 0", bus.ft_din_valid); end
    step(); bus.src_req = '0; #1;
    checks++; if (bus.ft_din !== 16'h2003 || bus.ft_din_valid !== 1'b1) begin errors++; $display("FAIL single_hdr: din=%h valid=%b want 2003/1", bus.ft_din, bus.ft_din_valid); end
    checks++; if (bus.src_ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b want 0100", bus.src_ack); end
    checks++; if (bus.ft_din_be !== 2'b11 || bus.src_ready !== 4'b0000) begin errors++; $display("FAIL single_hdr_be: be=%b ready=%b want 11/0000", bus.ft_din_be, bus.src_ready); end
    step(); #1;
    checks++; if (bus.ft_din !== 16'hA0A0 || bus.ft_din_valid !== 1'b1 || bus.src_ready !== 4'b0100) begin errors++; $display("FAIL single_d0: din=%h valid=%b ready=%b want a0a0/1/0100", bus.ft_din, bus.ft_din_valid, bus.src_ready); end
    checks++; if (bus.src_ack !== 4'b0000) begin errors++; $display("FAIL single_ack_once: got %b want 0000", bus.src_ack); end
    step(); set_data(2, 16'hB0B1); #1;
    checks++; if (bus.ft_din !== 16'hB0B1 || bus.ft_din_valid !== 1'b1) begin errors++; $display("FAIL single_d1: din=%h valid=%b want b0b1/1", bus.ft_din, bus.ft_din_valid); end
    step(); set_data(2, 16'hC0C2); #1;
    checks++; if (bus.ft_din !== 16'hC0C2 || bus.ft_din_valid !== 1'b1) begin errors++; $display("FAIL single_d2: din=%h valid=%b want c0c2/1", bus.ft_din, bus.ft_din_valid); end
    step(); bus.src_valid = '0; #1;
    checks++; if (bus.ft_din_valid !== 1'b0 || bus.src_ready !== 4'b0000) begin errors++; $display("FAIL single_end: valid=%b ready=%b want 0/0000", bus.ft_din_valid, bus.src_ready); end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_hdr;
    int ch;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.src_req = 4'b1111; bus.src_valid = 4'b1111;
    for (int c = 0; c < CH; c++) begin set_len(c, 1); set_data(c, 16'hD000 + 16'(c)); end
    #1;
    for (int k = 0; k < 5; k++) begin
      ch = k % CH;
      exp_hdr = {4'(ch), 12'h001};
      step(); #1;
      checks++; if (bus.ft_din !== exp_hdr || bus.src_ack !== 4'(1 << ch)) begin errors++; $display("FAIL rr_hdr%0d: din=%h ack=%b want %h/%b", k, bus.ft_din, bus.src_ack, exp_hdr, 4'(1 << ch)); end
      step(); #1;
      checks++; if (bus.ft_din !== 16'hD000 + 16'(ch) || bus.src_ready !== 4'(1 << ch) || bus.ft_din_valid !== 1'b1) begin errors++; $display("FAIL rr_data%0d: din=%h ready=%b want %h/%b", k, bus.ft_din, bus.src_ready, 16'hD000 + 16'(ch), 4'(1 << ch)); end
      step();
      if (k == 4) begin bus.src_req = '0; bus.src_valid = '0; end
      #1;
      checks++; if (bus.ft_din_valid !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: valid=%b want 0", k, bus.ft_din_valid); end
    end
  endtask

  task automatic test_zero_len_order();
    for (int c = 0; c < CH; c++) set_len(c, 0);
    step(); bus.src_req = 4'b0010; #1;
    step(); bus.src_req = '0; #1;
    checks++; if (bus.ft_din !== 16'h1000 || bus.src_ack !== 4'b0010) begin errors++; $display("FAIL zl_hdr1: din=%h ack=%b want 1000/0010", bus.ft_din, bus.src_ack); end
    step(); bus.src_req = 4'b1011; #1;
    checks++; if (bus.ft_din_valid !== 1'b0 || bus.src_ready !== 4'b0000) begin errors++; $display("FAIL zl_idle: valid=%b ready=%b want 0/0000", bus.ft_din_valid, bus.src_ready); end
    step(); bus.src_req = 4'b0011; #1;
    checks++; if (bus.ft_din !== 16'h3000 || bus.src_ack !== 4'b1000) begin errors++; $display("FAIL order_first: din=%h ack=%b want 3000/1000", bus.ft_din, bus.src_ack); end
    step(); #1;
    checks++; if (bus.ft_din_valid !== 1'b0 || bus.src_ready !== 4'b0000) begin errors++; $display("FAIL order_gap1: valid=%b ready=%b want 0/0000", bus.ft_din_valid, bus.src_ready); end
    step(); bus.src_req = 4'b0010; #1;
    checks++; if (bus.ft_din !== 16'h0000 || bus.src_ack !== 4'b0001 || bus.ft_din_valid !== 1'b1) begin errors++; $display("FAIL order_second: din=%h ack=%b want 0000/0001", bus.ft_din, bus.src_ack); end
    step(); #1;
    step(); bus.src_req = '0; #1;
    checks++; if (bus.ft_din !== 16'h1000 || bus.src_ack !== 4'b0010) begin errors++; $display("FAIL order_third: din=%h ack=%b want 1000/0010", bus.ft_din, bus.src_ack); end
    step(); #1;
    checks++; if (bus.ft_din_valid !== 1'b0 || bus.src_ready !== 4'b0000) begin errors++; $display("FAIL order_end: valid=%b ready=%b want 0/0000", bus.ft_din_valid, bus.src_ready); end
  endtask

  task automatic test_backpressure();
    step(); bus.src_req = 4'b0010; set_len(1, 4); bus.src_valid[1] = 1'b1; set_data(1, 16'h1110); #1;
    step(); bus.src_req = '0; #1;
    checks++; if (bus.ft_din !== 16'h1004) begin errors++; $display("FAIL bp_hdr: din=%h want 1004", bus.ft_din); end
    step(); #1;
    checks++; if (bus.ft_din !== 16'h1110 || bus.ft_din_valid !== 1'b1) begin errors++; $display("FAIL bp_w0: din=%h valid=%b want 1110/1", bus.ft_din, bus.ft_din_valid); end
    step(); set_data(1, 16'h1111); bus.ft_din_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      #1;
      checks++; if (bus.ft_din_valid !== 1'b0 || bus.src_ready !== 4'b0000) begin errors++; $display("FAIL bp_full%0d: valid=%b ready=%b want 0/0000", i, bus.ft_din_valid, bus.src_ready); end
    end
    step(); bus.ft_din_full = 1'b0; #1;
    checks++; if (bus.ft_din !== 16'h1111 || bus.ft_din_valid !== 1'b1 || bus.src_ready !== 4'b0010) begin errors++; $display("FAIL bp_w1: din=%h valid=%b ready=%b want 1111/1/0010", bus.ft_din, bus.ft_din_valid, bus.src_ready); end
    step(); set_data(1, 16'h1112); bus.src_valid[1] = 1'b0; #1;
    checks++; if (bus.ft_din_valid !== 1'b0 || bus.src_ready !== 4'b0010) begin errors++; $display("FAIL bp_hold: valid=%b ready=%b want 0/0010", bus.ft_din_valid, bus.src_ready); end
    step(); bus.src_valid[1] = 1'b1; #1;
    checks++; if (bus.ft_din !== 16'h1112 || bus.ft_din_valid !== 1'b1) begin errors++; $display("FAIL bp_w2: din=%h valid=%b want 1112/1", bus.ft_din, bus.ft_din_valid); end
    step(); set_data(1, 16'h1113); #1;
    checks++; if (bus.ft_din !== 16'h1113 || bus.ft_din_valid !== 1'b1) begin errors++; $display("FAIL bp_w3: din=%h valid=%b want 1113/1", bus.ft_din, bus.ft_din_valid); end
    step(); bus.src_valid = '0; #1;
    checks++; if (bus.ft_din_valid !== 1'b0 || bus.src_ready !== 4'b0000) begin errors++; $display("FAIL bp_end: valid=%b ready=%b want 0/0000", bus.ft_din_valid, bus.src_ready); end
  endtask

  task automatic test_max_burst();
    step(); bus.src_req = 4'b0001; set_len(0, 200); bus.src_valid[0] = 1'b1; set_data(0, 16'h0100); #1;
    step(); bus.src_req = '0; #1;
    checks++; if (bus.ft_din !== 16'h0040) begin errors++; $display("FAIL mb_hdr: din=%h want 0040", bus.ft_din); end
    for (int i = 0; i < 64; i++) begin
      step(); set_data(0, 16'h0100 + 16'(i)); #1;
      checks++; if (bus.ft_din !== 16'h0100 + 16'(i) || bus.ft_din_valid !== 1'b1) begin errors++; $display("FAIL mb_word%0d: din=%h valid=%b want %h/1", i, bus.ft_din, bus.ft_din_valid, 16'h0100 + 16'(i)); end
    end
    step(); #1;
    checks++; if (bus.ft_din_valid !== 1'b0 || bus.src_ready !== 4'b0000) begin errors++; $display("FAIL mb_end: valid=%b ready=%b want 0/0000", bus.ft_din_valid, bus.src_ready); end
    bus.src_valid = '0;
  endtask

  task automatic test_reset_mid();
    step(); bus.src_req = 4'b0100; set_len(2, 5); bus.src_valid[2] = 1'b1; set_data(2, 16'h2220); #1;
    step(); bus.src_req = '0; #1;
    checks++; if (bus.ft_din !== 16'h2005) begin errors++; $display("FAIL rm_hdr: din=%h want 2005", bus.ft_din); end
    step(); #1;
    step(); rst = 1'b1; #1;
    checks++; if (bus.ft_din_valid !== 1'b0 || bus.src_ready !== 4'b0000) begin errors++; $display("FAIL rm_drop: valid=%b ready=%b want 0/0000", bus.ft_din_valid, bus.src_ready); end
    step(); rst = 1'b0; #1;
    checks++; if (bus.ft_din_valid !== 1'b0 || bus.src_ready !== 4'b0000) begin errors++; $display("FAIL rm_idle: valid=%b ready=%b want 0/0000", bus.ft_din_valid, bus.src_ready); end
    bus.src_valid = '0;
  endtask

  task automatic test_timeout();
    step(); bus.src_req = 4'b1000; set_len(3, 4); bus.src_valid[3] = 1'b1; set_data(3, 16'h3330); #1;
    step(); bus.src_req = '0; #1;
    checks++; if (bus.ft_din !== 16'h3004) begin errors++; $display("FAIL to_hdr: din=%h want 3004", bus.ft_din); end
    step(); #1;
    checks++; if (bus.ft_din !== 16'h3330 || bus.ft_din_valid !== 1'b1) begin errors++; $display("FAIL to_w0: din=%h valid=%b want 3330/1", bus.ft_din, bus.ft_din_valid); end
    step(); bus.src_valid[3] = 1'b0;
`ifdef FT_ARB_TIMEOUT_EN
    for (int s = 1; s <= 8; s++) begin
      if (s > 1) step();
      #1;
      checks++; if (bus.abort !== (s == 8) || bus.ft_din_valid !== 1'b0) begin errors++; $display("FAIL to_stall%0d: abort=%b valid=%b want %b/0", s, bus.abort, bus.ft_din_valid, (s == 8)); end
    end
    for (int p = 0; p < 3; p++) begin
      step(); #1;
      checks++; if (bus.ft_din_valid !== 1'b1 || bus.ft_din !== 16'h0000 || bus.ft_din_be !== 2'b00 || bus.src_ready !== 4'b0000 || bus.abort !== 1'b0) begin errors++; $display("FAIL to_pad%0d: valid=%b din=%h be=%b ready=%b abort=%b want 1/0000/00/0000/0", p, bus.ft_din_valid, bus.ft_din, bus.ft_din_be, bus.src_ready, bus.abort); end
    end
    step(); #1;
    checks++; if (bus.ft_din_valid !== 1'b0) begin errors++; $display("FAIL to_end: valid=%b want 0", bus.ft_din_valid); end
`else
    for (int s = 1; s <= 20; s++) begin
      if (s > 1) step();
      #1;
      checks++; if (bus.abort !== 1'b0 || bus.ft_din_valid !== 1'b0 || bus.src_ready !== 4'b1000) begin errors++; $display("FAIL hold%0d: abort=%b valid=%b ready=%b want 0/0/1000", s, bus.abort, bus.ft_din_valid, bus.src_ready); end
    end
    for (int w = 1; w < 4; w++) begin
      step(); bus.src_valid[3] = 1'b1; set_data(3, 16'h3330 + 16'(w)); #1;
      checks++; if (bus.ft_din !== 16'h3330 + 16'(w) || bus.ft_din_valid !== 1'b1) begin errors++; $display("FAIL hold_w%0d: din=%h valid=%b want %h/1", w, bus.ft_din, bus.ft_din_valid, 16'h3330 + 16'(w)); end
    end
    step(); bus.src_valid = '0; #1;
    checks++; if (bus.ft_din_valid !== 1'b0) begin errors++; $display("FAIL hold_end: valid=%b want 0", bus.ft_din_valid); end
`endif
    bus.src_valid = '0;
  endtask

  initial begin
    bus.src_req     = '0;
    bus.src_len     = '0;
    bus.src_data    = '0;
    bus.src_be      = '0;
    bus.src_valid   = '0;
    bus.ft_din_full = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_zero_len_order();
    test_backpressure();
    test_max_burst();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
